// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Definitions shared by the SDRAM controller and its client-side tester:
//   - client word-address geometry (bank + row + col) and data width
//   - one-hot state encoding of the sdram_tester sequencer
// -----------------------------------------------------------------------------
package sdram_pkg;

  // Client-interface geometry, shared with the controller.
  localparam int unsigned SDRAM_BANK_WIDTH = 2;
  localparam int unsigned SDRAM_ROW_WIDTH  = 12;
  localparam int unsigned SDRAM_COL_WIDTH  = 8;
  localparam int unsigned SDRAM_ADDR_WIDTH = SDRAM_BANK_WIDTH + SDRAM_ROW_WIDTH
                                           + SDRAM_COL_WIDTH;
  localparam int unsigned SDRAM_DATA_WIDTH = 16;

  // Tester sequencer states, one-hot.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WR_REQ  = 6'b000010,
    ST_WR_GAP  = 6'b000100,
    ST_RD_REQ  = 6'b001000,
    ST_RD_WAIT = 6'b010000,
    ST_DONE    = 6'b100000
  } tester_state_e;

endpackage : sdram_pkg

// File: rtl/sdram_tester_wdog.sv
// -----------------------------------------------------------------------------
// sdram_tester_wdog
//   Loadable down-counter used as the tester's stall watchdog.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset
//     clr_i        - force the count to zero (used while nothing is watched)
//     load_i       - load load_val_i (highest priority)
//     en_i         - count down by one per cycle, stopping at zero
//     load_val_i   - value loaded on load_i
//     expired_o    - count has reached zero while enabled
// -----------------------------------------------------------------------------
module sdram_tester_wdog #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: the next-state value defaults to the current one before any
    // condition is tested, so no branch can leave it unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of block ordering.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only meaningful while counting; an idle, cleared counter never fires.
  assign expired_o = en_i && (cnt_q == '0);

endmodule : sdram_tester_wdog

// File: rtl/sdram_tester.sv
// -----------------------------------------------------------------------------
// sdram_tester
//   Client-side traffic generator/checker for the SDRAM controller. On start
//   it writes P(a) = a[DATA_WIDTH-1:0] ^ SEED to every word 0..ADDR_LAST,
//   reads all of them back and compares, then reports the outcome.
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     start               - one-cycle pulse, accepted only when idle
//     sdram_req/ack       - client request / one-cycle accept from controller
//     sdram_addr/rh_wl    - word address, 1=read 0=write
//     sdram_data_w        - write data
//     sdram_data_r/_en    - read data and its valid pulse
//     busy                - test running
//     done/pass/timeout   - sticky result flags
//     err_count           - saturating mismatch count
//     first_err_addr/data - address and read data of the first mismatch
// -----------------------------------------------------------------------------
module sdram_tester
  import sdram_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int unsigned            DATA_WIDTH = SDRAM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_LAST  = {ADDR_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0]  SEED       = 16'hA5C3,
  parameter int unsigned            WR_GAP     = 4,
  parameter int unsigned            TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic                  sdram_rh_wl,
  output logic [DATA_WIDTH-1:0] sdram_data_w,
  input  logic [DATA_WIDTH-1:0] sdram_data_r,
  input  logic                  sdram_data_r_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  // Gap counter runs 0..WR_GAP-1 inside ST_WR_GAP.
  localparam int unsigned       GAP_W    = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(WR_GAP - 1);

  // Loading TIMEOUT-1 makes the watchdog fire on the TIMEOUT-th waiting
  // cycle, so the abort edge lands exactly TIMEOUT clocks after state entry.
  localparam int unsigned       WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LOAD  = WD_W'(TIMEOUT - 1);

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) ^ SEED;
  endfunction

  tester_state_e           state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [GAP_W-1:0]        gap_q,     gap_d;
  logic                    rh_wl_q,   rh_wl_d;
  logic [DATA_WIDTH-1:0]   data_w_q,  data_w_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    pass_q,    pass_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             err_q,     err_d;
  logic [ADDR_WIDTH-1:0]   ferr_addr_q, ferr_addr_d;
  logic [DATA_WIDTH-1:0]   ferr_data_q, ferr_data_d;

  logic                    addr_is_last;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    watched;
  logic                    wd_load;
  logic                    wd_expired;

  assign addr_is_last = (addr_q == ADDR_LAST);
  assign addr_inc     = addr_q + ADDR_WIDTH'(1);
  assign watched      = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ)
                     || (state_q == ST_RD_WAIT);

  // Every ack or read-data event in a watched state causes a transition, so
  // reloading on any state change also covers the ack/data_r_en restarts.
  assign wd_load = (state_d != state_q);

  sdram_tester_wdog #(
    .WIDTH (WD_W)
  ) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (!watched),
    .load_i     (wd_load),
    .en_i       (watched),
    .load_val_i (WD_LOAD),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    gap_d       = gap_q;
    rh_wl_d     = rh_wl_q;
    data_w_d    = data_w_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          addr_d      = '0;
          rh_wl_d     = 1'b0;
          data_w_d    = pattern('0);
          busy_d      = 1'b1;
          state_d     = ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        if (sdram_ack) begin
          gap_d   = '0;
          state_d = ST_WR_GAP;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      // Address/data only change on the edge that re-enters a request state,
      // which keeps them stable for the controller after each ack.
      ST_WR_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (addr_is_last) begin
            addr_d  = '0;
            rh_wl_d = 1'b1;
            state_d = ST_RD_REQ;
          end else begin
            addr_d   = addr_inc;
            data_w_d = pattern(addr_inc);
            state_d  = ST_WR_REQ;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_RD_REQ: begin
        if (sdram_ack) begin
          state_d = ST_RD_WAIT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_RD_WAIT: begin
        if (sdram_data_r_en) begin
          if (sdram_data_r != pattern(addr_q)) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (err_q == '0) begin
              ferr_addr_d = addr_q;
              ferr_data_d = sdram_data_r;
            end
          end
          if (addr_is_last) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_inc;
            state_d = ST_RD_REQ;
          end
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0) && !timeout_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      gap_q       <= '0;
      rh_wl_q     <= 1'b0;
      data_w_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      gap_q       <= gap_d;
      rh_wl_q     <= rh_wl_d;
      data_w_q    <= data_w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  // Request is decoded from state and gated by reset so an abort withdraws
  // it immediately rather than one edge later.
  assign sdram_req      = ((state_q == ST_WR_REQ) || (state_q == ST_RD_REQ)) && !reset;
  assign sdram_addr     = addr_q;
  assign sdram_rh_wl    = rh_wl_q;
  assign sdram_data_w   = data_w_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule : sdram_tester
